// File: rtl/sll_seq.sv
// Sequential logical shift-left: B << n, one bit per clock after a start strobe.
// Optional build macro SLL_SEQ_VAR_EN adds S/var_sel to source the amount from a register.
module sll_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef SLL_SEQ_VAR_EN
  input  logic [31:0] S,
  input  logic        var_sel,
`endif
  output logic [31:0] res,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] data_r;
  logic [4:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic [4:0]  n_s;

`ifdef SLL_SEQ_VAR_EN
  wire unused_ok_s = ^{A[31:11], A[5:0], S[31:5]};
`else
  wire unused_ok_s = ^{A[31:11], A[5:0]};
`endif

  // Shift amount selection; only the low five bits of either source matter.
  always_comb begin
    n_s = A[10:6];
`ifdef SLL_SEQ_VAR_EN
    if (var_sel) begin
      n_s = S[4:0];
    end else begin
      n_s = A[10:6];
    end
`endif
  end

  // Control FSM and datapath; busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      data_r  <= 32'd0;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            data_r  <= B;
            cnt_r   <= n_s;
            state_r <= SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        SHIFT: begin
          // Start is deliberately ignored here; operands were captured at acceptance.
          if (cnt_r != 5'd0) begin
            data_r <= {data_r[30:0], 1'b0};
            cnt_r  <= cnt_r - 5'd1;
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end else begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign res  = data_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_sll_seq.sv
// Self-checking bench for sll_seq: directed scenarios plus randomized traffic
// compared every cycle against a timing/arithmetic model of the shifter.
module tb_sll_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
`ifdef SLL_SEQ_VAR_EN
  logic [31:0] S;
  logic        var_sel;
`endif
  logic [31:0] res;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // model: one op accepted at edge acc with amount op_n finishes at edge acc+op_n+1
  int          cyc = 0;
  int          acc = 0;
  int          op_n = 0;
  bit          active = 1'b0;
  logic [31:0] op_res = 32'd0;
  logic [31:0] last_res = 32'd0;

  sll_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
`ifdef SLL_SEQ_VAR_EN
    .S       (S),
    .var_sel (var_sel),
`endif
    .res     (res),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int amount();
`ifdef SLL_SEQ_VAR_EN
    return var_sel ? int'(S[4:0]) : int'(A[10:6]);
`else
    return int'(A[10:6]);
`endif
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge, check outputs.
  task automatic step();
    bit was_busy;
    @(posedge clk);
    cyc++;
    if (active && cyc > acc + op_n + 1) active = 1'b0;
    was_busy = active && (cyc - 1 <= acc + op_n);
    if (start && !was_busy) begin
      acc    = cyc;
      op_n   = amount();
      op_res = B << op_n;
      active = 1'b1;
    end
    #1;
    if (active && cyc <= acc + op_n) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_run", {31'd0, done}, 32'd0);
    end else if (active && cyc == acc + op_n + 1) begin
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("res_done", res, op_res);
      last_res = op_res;
    end else begin
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("done_idle", {31'd0, done}, 32'd0);
      chk("res_hold", res, last_res);
    end
  endtask

  // Assert reset between edges and confirm the asynchronous clear.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_res", res, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    active   = 1'b0;
    last_res = 32'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation with literal expectations; optional disturbance of B and start mid-run.
  task automatic run_op(input logic [31:0] b, input logic [4:0] amt,
                        input logic [31:0] exp_res, input int exp_lat, input bit disturb);
    int lat;
    int busy_cnt;
    A = $urandom;
    A[10:6] = amt;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (disturb && lat == 3) B = $urandom;
      start = (disturb && lat == 10) ? 1'b1 : 1'b0;
      A = $urandom;
      step();
      lat++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk("lit_latency", lat, exp_lat);
    chk("lit_busy_cycles", busy_cnt, exp_lat);
    chk("lit_res", res, exp_res);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = 32'd0;
    B = 32'd0;
`ifdef SLL_SEQ_VAR_EN
    S = 32'd0;
    var_sel = 1'b0;
`endif
    #3;
    chk("por_res", res, 32'd0);
    chk("por_busy", {31'd0, busy}, 32'd0);
    chk("por_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step();
    run_op(32'h0000_0001, 5'd4, 32'h0000_0010, 5, 1'b0);
    step();
    run_op(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b0);
    step();
    step();
    run_op(32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 32, 1'b1);
    // back-to-back: second start lands on the DONE cycle of the first
    run_op(32'h0000_0F0F, 5'd2, 32'h0000_3C3C, 3, 1'b0);
    run_op(32'h0000_00F0, 5'd8, 32'h0000_F000, 9, 1'b0);
    step();

    // reset three cycles into an n=20 shift
    A = $urandom;
    A[10:6] = 5'd20;
    B = 32'h1234_5678;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    do_reset();
    repeat (25) step();
    run_op(32'h0000_0005, 5'd1, 32'h0000_000A, 2, 1'b0);

`ifdef SLL_SEQ_VAR_EN
    var_sel = 1'b1;
    S = 32'hFFFF_FFE3;
    run_op(32'h0000_0003, 5'd1, 32'h0000_0018, 4, 1'b0);
    var_sel = 1'b0;
`endif

    // randomized traffic, including starts while busy and edge amounts
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      A = $urandom;
      case ($urandom_range(0, 3))
        0: A[10:6] = 5'd0;
        1: A[10:6] = 5'd31;
        default: A[10:6] = 5'($urandom_range(0, 31));
      endcase
      B = $urandom;
`ifdef SLL_SEQ_VAR_EN
      S = $urandom;
      var_sel = $urandom_range(0, 1);
`endif
      step();
      if (i == 700) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sll_seq.md
SLL_SEQ -- requirements
Module: sll_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request strobe; sampled on rising clk.
REQ-004 A  input  32  instruction word; shift amount field A[10:6].
REQ-005 B  input  32  operand to be shifted left.
REQ-006 S  input  32  register-sourced shift amount, S[4:0] used; present only with SLL_SEQ_VAR_EN.
REQ-007 var_sel  input  1  1 = take amount from S[4:0], 0 = from A[10:6]; present only with SLL_SEQ_VAR_EN.
REQ-008 res  output  32  shift result; held stable between operations.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse; res valid in the same cycle.

Function
REQ-011 The block SHALL compute res = B << n, logical, zero fill, where n is the 5-bit amount (0..31).
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 Acceptance: start=1 at a rising edge in IDLE or DONE loads data_reg<=B and cnt<=n, and moves to SHIFT.
REQ-014 In SHIFT with cnt!=0, each edge SHALL do data_reg<=data_reg<<1 and cnt<=cnt-1.
REQ-015 In SHIFT with cnt==0, the next edge SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle, then go to IDLE unless start=1, in which case REQ-013 applies.
REQ-017 Latency: done SHALL be high in the cycle that begins n+1 edges after the acceptance edge (n=0 gives 1 cycle; n=31 gives 32 cycles).
REQ-018 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-019 res SHALL be driven from data_reg and be valid in DONE.
REQ-020 res SHALL hold the last result in IDLE until the next acceptance; it may show intermediate values while busy=1.
REQ-021 start while busy=1 SHALL be ignored; operands are not re-sampled and the operation in progress is unaffected.
REQ-022 A, B, S and var_sel SHALL be sampled only on the acceptance edge; later changes have no effect on the running operation.
REQ-023 Only the low 5 bits of the amount SHALL be used; no output is produced for n greater than or equal to 32.

Reset
REQ-024 rst=1 SHALL, asynchronously: state<=IDLE, data_reg<=0 (res=0), cnt<=0, busy=0, done=0.
REQ-025 rst asserted mid-operation SHALL abandon the operation; no done pulse follows for it.
REQ-026 After rst deasserts, the first start at a rising edge SHALL be accepted normally.

Configuration
REQ-027 Macro SLL_SEQ_VAR_EN, when defined, SHALL add ports S and var_sel and select n = var_sel ? S[4:0] : A[10:6].
REQ-028 Without SLL_SEQ_VAR_EN, ports S and var_sel SHALL be absent and n = A[10:6] always.
REQ-029 Timing, FSM and reset behaviour SHALL be identical in both builds.

Verification
REQ-030 Scenario: B=32'h0000_0001, A[10:6]=4, start pulse -> done 5 cycles after acceptance, res=32'h0000_0010, busy high for 5 cycles.
REQ-031 Scenario: B=32'hDEAD_BEEF, A[10:6]=0 -> done 1 cycle after acceptance, res=32'hDEAD_BEEF.
REQ-032 Scenario: B=32'hFFFF_FFFF, A[10:6]=31 -> done after 32 cycles, res=32'h8000_0000; a second start at cycle 10 is ignored and B change at cycle 3 has no effect.
REQ-033 Scenario: start held high through DONE with new B=32'h0000_00F0, A[10:6]=8 -> back-to-back done pulses, second res=32'h0000_F000.
REQ-034 Scenario: rst asserted 3 cycles into an n=20 shift -> immediate res=0, busy=0, done=0, no later done; next start works normally.
REQ-035 Scenario (SLL_SEQ_VAR_EN): var_sel=1, S=32'hFFFF_FFE3, A[10:6]=1, B=32'h0000_0003 -> n=3, res=32'h0000_0018 after 4 cycles.
